// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit
// Brief    : 8-operation ALU with start/done handshake and 8-cycle shift-add MUL
// Revision : 1.0
// ============================================================================
module alu_unit #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             send,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int                c_cntW     = $clog2(MUL_CYCLES);
  localparam logic [c_cntW-1:0] c_lastIter = c_cntW'(MUL_CYCLES - 1);

  localparam logic [2:0] c_opAdd = 3'b000;
  localparam logic [2:0] c_opSub = 3'b001;
  localparam logic [2:0] c_opAnd = 3'b010;
  localparam logic [2:0] c_opOr  = 3'b011;
  localparam logic [2:0] c_opXor = 3'b100;
  localparam logic [2:0] c_opShl = 3'b101;
  localparam logic [2:0] c_opShr = 3'b110;
  localparam logic [2:0] c_opMul = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t r_state, w_stateNext;

  logic [WIDTH-1:0]   r_result,   w_resultNext;
  logic               r_carry,    w_carryNext;
  logic               r_zero,     w_zeroNext;
  logic               r_negative, w_negativeNext;
  logic               r_overflow, w_overflowNext;
  logic               r_busy,     w_busyNext;
  logic               r_done,     w_doneNext;
  logic [2*WIDTH-1:0] r_mcand,    w_mcandNext;
  logic [WIDTH-1:0]   r_mplier,   w_mplierNext;
  logic [2*WIDTH-1:0] r_product,  w_productNext;
  logic [c_cntW-1:0]  r_count,    w_countNext;

  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH-1:0]   w_aluRes;
  logic               w_aluCarry, w_aluOvf;
  logic [2*WIDTH-1:0] w_prodNext;

  assign w_sum  = {1'b0, dataA} + {1'b0, dataB};
  assign w_diff = {1'b0, dataA} - {1'b0, dataB};

  // Single-cycle datapath; bit WIDTH of w_diff is the unsigned borrow.
  always_comb begin
    w_aluRes   = '0;
    w_aluCarry = 1'b0;
    w_aluOvf   = 1'b0;
    case (op)
      c_opAdd: begin
        w_aluRes   = w_sum[WIDTH-1:0];
        w_aluCarry = w_sum[WIDTH];
        w_aluOvf   = (dataA[WIDTH-1] == dataB[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != dataA[WIDTH-1]);
      end
      c_opSub: begin
        w_aluRes   = w_diff[WIDTH-1:0];
        w_aluCarry = w_diff[WIDTH];
        w_aluOvf   = (dataA[WIDTH-1] != dataB[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != dataA[WIDTH-1]);
      end
      c_opAnd: w_aluRes = dataA & dataB;
      c_opOr:  w_aluRes = dataA | dataB;
      c_opXor: w_aluRes = dataA ^ dataB;
      c_opShl: begin
        w_aluRes   = {dataA[WIDTH-2:0], 1'b0};
        w_aluCarry = dataA[WIDTH-1];
      end
      c_opShr: begin
        w_aluRes   = {1'b0, dataA[WIDTH-1:1]};
        w_aluCarry = dataA[0];
      end
      default: ;
    endcase
  end

  assign w_prodNext = r_product + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_stateNext    = r_state;
    w_resultNext   = r_result;
    w_carryNext    = r_carry;
    w_zeroNext     = r_zero;
    w_negativeNext = r_negative;
    w_overflowNext = r_overflow;
    w_busyNext     = r_busy;
    w_doneNext     = 1'b0;
    w_mcandNext    = r_mcand;
    w_mplierNext   = r_mplier;
    w_productNext  = r_product;
    w_countNext    = r_count;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (op == c_opMul) begin
            w_mcandNext   = {{WIDTH{1'b0}}, dataA};
            w_mplierNext  = dataB;
            w_productNext = '0;
            w_countNext   = '0;
            w_busyNext    = 1'b1;
            w_stateNext   = MUL;
          end else begin
            w_resultNext   = w_aluRes;
            w_carryNext    = w_aluCarry;
            w_overflowNext = w_aluOvf;
            w_zeroNext     = (w_aluRes == '0);
            w_negativeNext = w_aluRes[WIDTH-1];
            w_doneNext     = 1'b1;
          end
        end
      end
      MUL: begin
        w_productNext = w_prodNext;
        w_mcandNext   = r_mcand << 1;
        w_mplierNext  = r_mplier >> 1;
        w_countNext   = r_count + c_cntW'(1);
        if (r_count == c_lastIter) begin
          w_resultNext   = w_prodNext[WIDTH-1:0];
          w_carryNext    = |w_prodNext[2*WIDTH-1:WIDTH];
          w_overflowNext = 1'b0;
          w_zeroNext     = (w_prodNext[WIDTH-1:0] == '0);
          w_negativeNext = w_prodNext[WIDTH-1];
          w_busyNext     = 1'b0;
          w_doneNext     = 1'b1;
          w_stateNext    = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_product  <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_result   <= w_resultNext;
      r_carry    <= w_carryNext;
      r_zero     <= w_zeroNext;
      r_negative <= w_negativeNext;
      r_overflow <= w_overflowNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_mcand    <= w_mcandNext;
      r_mplier   <= w_mplierNext;
      r_product  <= w_productNext;
      r_count    <= w_countNext;
    end
  end

  assign result   = r_result;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign negative = r_negative;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign done     = r_done;
  assign dataOut  = send ? r_result : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_unit
// Brief    : Scoreboard bench for alu_unit: expected results queued at issue,
//            popped and compared on every done pulse
// Revision : 1.0
// ============================================================================
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dataA = '0;
  logic [7:0] dataB = '0;
  logic [2:0] op = '0;
  logic       start = 1'b0;
  logic       send = 1'b0;
  wire  [7:0] dataOut;
  logic [7:0] result;
  logic       carry, zero, negative, overflow, busy, done;

  alu_unit #(.WIDTH(8), .MUL_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .op(op),
    .start(start), .send(send), .dataOut(dataOut), .result(result),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       c, z, n, v;
  } exp_t;

  exp_t sb[$];
  int   nCompared  = 0;
  int   nMismatched = 0;
  int   doneCount  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0]  s;
    logic [15:0] p;
    e = '0;
    case (o)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[7:0]; e.c = s[8];
        e.v = (a[7] == b[7]) && (e.res[7] != a[7]);
      end
      3'd1: begin
        e.res = a - b; e.c = (a < b);
        e.v = (a[7] != b[7]) && (e.res[7] != a[7]);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin e.res = {a[6:0], 1'b0}; e.c = a[7]; end
      3'd6: begin e.res = {1'b0, a[7:1]}; e.c = a[0]; end
      default: begin
        p = 16'(a) * 16'(b);
        e.res = p[7:0]; e.c = (p[15:8] != 8'h00);
      end
    endcase
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      doneCount++;
      if (sb.size() == 0) begin
        checkVal("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkVal("result",   {24'h0, result}, {24'h0, e.res});
        checkVal("carry",    {31'h0, carry},    {31'h0, e.c});
        checkVal("zero",     {31'h0, zero},     {31'h0, e.z});
        checkVal("negative", {31'h0, negative}, {31'h0, e.n});
        checkVal("overflow", {31'h0, overflow}, {31'h0, e.v});
      end
    end
  end

  // Drives start for one edge; returns at the negedge following that edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; dataA = a; dataB = b; start = 1'b1;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    #1;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkVal(tag, sb.size(), 32'd0);
  endtask

  task automatic runOne(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    issue(o, a, b);
    drain("op_timeout", 12);
  endtask

  initial begin
    int n;
    int d0;
    logic [31:0] zz;
    zz = {24'h0, 8'hzz};

    // Reset
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("rst_result", {24'h0, result}, 32'h0);
    checkVal("rst_flags", {28'h0, carry, zero, negative, overflow}, 32'h0);
    checkVal("rst_busy", {31'h0, busy}, 32'h0);
    checkVal("rst_done", {31'h0, done}, 32'h0);
    checkVal("rst_dataOut_z", {24'h0, dataOut}, zz);

    // Directed single-cycle ops
    runOne(3'd0, 8'h0C, 8'hF8);
    send = 1'b1; #1;
    checkVal("send_dataOut", {24'h0, dataOut}, 32'h04);
    send = 1'b0; #1;
    checkVal("nosend_dataOut_z", {24'h0, dataOut}, zz);
    runOne(3'd0, 8'h7F, 8'h01);
    runOne(3'd1, 8'h0C, 8'h0D);
    runOne(3'd1, 8'h0C, 8'h0C);
    runOne(3'd1, 8'h80, 8'h01);
    runOne(3'd2, 8'hF0, 8'h3C);
    runOne(3'd3, 8'hF0, 8'h0C);
    runOne(3'd4, 8'hAA, 8'hAA);
    runOne(3'd5, 8'h81, 8'h55);
    runOne(3'd6, 8'h81, 8'h55);
    checkVal("hold_result", {24'h0, result}, 32'h40);

    // MUL: busy high for exactly 8 cycles
    issue(3'd7, 8'h0C, 8'h15);
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    checkVal("mul_busy_cycles", n, 32'd8);
    drain("mul_timeout", 4);
    runOne(3'd7, 8'h10, 8'h20);

    // start during MUL is ignored; only the MUL completes
    d0 = doneCount;
    issue(3'd7, 8'h03, 8'h05);
    @(negedge clk);
    op = 3'd0; dataA = 8'h01; dataB = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dataA = 8'hFF; dataB = 8'hFF;
    drain("busy_ignore_timeout", 15);
    repeat (3) @(negedge clk);
    #1;
    checkVal("busy_ignore_dones", doneCount - d0, 32'd1);

    // Back-to-back: start in the done cycle is accepted
    issue(3'd0, 8'h11, 8'h22);
    issue(3'd1, 8'h05, 8'h09);
    #1;
    checkVal("b2b_latency", sb.size(), 32'd0);
    issue(3'd7, 8'hFF, 8'hFF);
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    issue(3'd4, 8'h5A, 8'hFF);
    #1;
    checkVal("mul_b2b_latency", sb.size(), 32'd0);

    // Randomized ops
    for (int i = 0; i < 24; i++) begin
      runOne(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end

    // Reset during MUL before the 4th iteration edge aborts it
    runOne(3'd0, 8'h33, 8'h44);
    issue(3'd7, 8'h0C, 8'h15);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    d0 = doneCount;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("abort_busy", {31'h0, busy}, 32'h0);
    checkVal("abort_result", {24'h0, result}, 32'h0);
    checkVal("abort_flags", {28'h0, carry, zero, negative, overflow}, 32'h0);
    repeat (12) @(negedge clk);
    #1;
    checkVal("abort_no_done", doneCount - d0, 32'd0);
    send = 1'b1; #1;
    checkVal("abort_dataOut", {24'h0, dataOut}, 32'h00);
    send = 1'b0; #1;
    checkVal("abort_dataOut_z", {24'h0, dataOut}, zz);

    checkVal("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
